alu_mc: RTL and testbench
=========================

Name: alu_mc

Overview:
- Parametrised, multi-cycle successor of the 4-bit registered ALU behind TOP/UTOP.
- Adds a valid/ready input handshake, an iterative signed multiplier and an accumulator.
- Keeps the existing ops (subtract, NAND, leading-ones, one-hot decode) and the four-bit flag vector.
- Sits between the operand source and the result consumer as a single-issue execution unit.

Parameters:
- WIDTH, 8, operand/result width in bits; legal range 4..32. Count results of the {B,A} ops need clog2(2*WIDTH+1) <= WIDTH bits.

Ports:
- i_clk  in  1  system clock, rising edge
- i_rst  in  1  reset, asynchronous, active-high
- i_arg0  in  WIDTH  operand A, signed
- i_arg1  in  WIDTH  operand B, signed
- i_oper  in  3  opcode
- i_valid  in  1  operation request
- o_ready  out  1  unit can accept; equals (state==IDLE)
- o_result  out  WIDTH  registered result, signed
- o_valid  out  1  one-cycle pulse, o_result/o_flag updated
- o_flag  out  4  [0] ERR, [1] NEG, [2] POS, [3] OVERFLOW

Behaviour:
- Reset (asynchronous, i_rst=1):
  - state=IDLE; o_result=0, o_flag=0, o_valid=0, o_ready=1; accumulator=0.
  - i_valid is ignored while i_rst=1.
- Accept occurs on the rising edge where i_valid & o_ready. A, B and opcode are captured only then; inputs are don't-care otherwise.
- Opcodes:
  - 000 SUB: Y=B-A, wrap to WIDTH; OVERFLOW on signed overflow.
  - 001 NAND: Y=~(A&B).
  - 010 LONES: Y=count of consecutive ones in {B,A} starting at the MSB of B; range 0..2*WIDTH.
  - 011 OHDEC: Y=index of the single set bit in {B,A} (0=LSB of A). Zero bits set, or more than one: Y=0, ERR=1.
  - 100 MUL: signed A*B via iterative shift-add (magnitudes, then sign fix). Y=low WIDTH bits; OVERFLOW if the product does not fit WIDTH signed.
  - 101 ACC: acc<=acc+A (wrap); Y=new acc; OVERFLOW on signed overflow.
  - 110 ACLR: acc<=0; Y=0.
  - 111 reserved: Y=0, ERR=1.
- Flags:
  - NEG = Y[WIDTH-1]; POS = (Y!=0) & ~Y[WIDTH-1]. Both are computed from the wrapped Y.
  - ERR and OVERFLOW are per-op as above, 0 otherwise.
  - Exactly one flag update per o_valid pulse; o_result/o_flag hold their value between pulses.
- FSM IDLE/MUL_RUN:
  - Non-MUL op: stays in IDLE. o_valid=1 in the cycle after the accept edge (latency 1), so back-to-back accepts give 1 result per cycle.
  - MUL: IDLE->MUL_RUN on accept; o_ready=0. Runs WIDTH iterations; on the final iteration returns to IDLE.
  - MUL o_valid pulses WIDTH+1 cycles after the accept edge; o_ready returns high in that same cycle.
- No output backpressure: the consumer must take the result on the o_valid pulse.
- Boundaries:
  - Reset mid-MUL aborts the operation: no o_valid, IDLE, accumulator cleared.
  - i_valid while o_ready=0 is ignored, not queued.
  - MUL with A = B = -2^(WIDTH-1): product 2^(2W-2), OVERFLOW=1.
  - SUB/ACC wrap, never saturate.

Decomposition:
- Package alu_pkg:
  - Opcode localparams: OP_SUB, OP_NAND, OP_LONES, OP_OHDEC, OP_MUL, OP_ACC, OP_ACLR.
  - Flag positions: FLAG_ERR=0, FLAG_NEG=1, FLAG_POS=2, FLAG_OVERFLOW=3.
  - State encoding.
- Sub-module alu_mul_iter:
  - Parameter WIDTH; ports i_clk, i_rst, i_start, i_a, i_b, o_done, o_prod[2*WIDTH-1:0].
  - Does the shift-add and sign fix; o_done asserts on the last iteration.
- alu_mc holds the handshake, FSM, single-cycle datapath, accumulator and flag logic.

Test Plan (WIDTH=8):
- Reset: i_rst=1 at t=0, released after 15 time units, then idle 2 cycles -> o_result=0, o_flag=0, o_valid=0, o_ready=1 throughout.
- SUB A=4,B=7 -> Y=3, flag=0100 after 1 cycle. SUB A=1,B=-128 -> Y=127 (0x7F), OVERFLOW=1, POS=1.
- Back-to-back, one per cycle:
  - NAND 0xFF,0x01 -> Y=0xFE, NEG=1.
  - LONES {B,A}=0xFF_F0 -> Y=12; then 0xFF_FF -> Y=16.
  - OHDEC 0x00_40 -> Y=6; then 0x00_41 -> Y=0, ERR=1.
  - o_valid high on 5 consecutive cycles.
- MUL A=-3,B=5 -> o_ready low for 8 cycles, o_valid 9 cycles after accept, Y=0xF1 (-15), NEG=1. A second i_valid during busy is ignored. MUL 16*16 -> Y=0x00, OVERFLOW=1.
- ACC sequence:
  - ACLR, then ACC A=100, then ACC A=100 -> Y=100 then Y=0xC8 (-56), OVERFLOW=1, NEG=1.
  - ACLR -> Y=0; then opcode 111 -> Y=0, ERR=1.
- Reset mid-MUL: assert i_rst 3 cycles after MUL accept -> no o_valid pulse, o_ready=1, next ACC A=1 gives Y=1.

Source files
------------

// File: rtl/alu_pkg.sv
// Shared opcodes, flag bit positions and FSM state encoding
// for the multi-cycle ALU.
package alu_pkg;

    localparam logic [2:0] OP_SUB   = 3'b000;
    localparam logic [2:0] OP_NAND  = 3'b001;
    localparam logic [2:0] OP_LONES = 3'b010;
    localparam logic [2:0] OP_OHDEC = 3'b011;
    localparam logic [2:0] OP_MUL   = 3'b100;
    localparam logic [2:0] OP_ACC   = 3'b101;
    localparam logic [2:0] OP_ACLR  = 3'b110;
    localparam logic [2:0] OP_RSVD  = 3'b111;

    localparam int FLAG_ERR      = 0;
    localparam int FLAG_NEG      = 1;
    localparam int FLAG_POS      = 2;
    localparam int FLAG_OVERFLOW = 3;

    typedef enum logic {
        IDLE    = 1'b0,
        MUL_RUN = 1'b1
    } state_t;

endpackage

// File: rtl/alu_mc_if.sv
// Request/result bundle between operand source, ALU and consumer.
// The ALU takes the slave side; the source/consumer takes master.
interface alu_mc_if #(
    parameter int WIDTH = 8
);
    logic [WIDTH-1:0] i_arg0;
    logic [WIDTH-1:0] i_arg1;
    logic [2:0]       i_oper;
    logic             i_valid;
    logic             o_ready;
    logic [WIDTH-1:0] o_result;
    logic             o_valid;
    logic [3:0]       o_flag;

    modport master (
        output i_arg0, i_arg1, i_oper, i_valid,
        input  o_ready, o_result, o_valid, o_flag
    );

    modport slave (
        input  i_arg0, i_arg1, i_oper, i_valid,
        output o_ready, o_result, o_valid, o_flag
    );
endinterface

// File: rtl/alu_mul_iter.sv
// Iterative signed multiplier: shift-add on magnitudes, sign applied
// to the final sum. One iteration per clock, WIDTH iterations total.
module alu_mul_iter #(
    parameter int WIDTH = 8
) (
    input  logic               i_clk,
    input  logic               i_rst,
    input  logic               i_start,
    input  logic [WIDTH-1:0]   i_a,
    input  logic [WIDTH-1:0]   i_b,
    output logic               o_done,
    output logic [2*WIDTH-1:0] o_prod
);
    localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

    logic [2*WIDTH-1:0] mcand_q;
    logic [WIDTH-1:0]   mplier_q;
    logic [2*WIDTH-1:0] sum_q;
    logic [2*WIDTH-1:0] sum_d;
    logic [CW-1:0]      cnt_q;
    logic               neg_q;
    logic               busy_q;
    logic [WIDTH-1:0]   mag_a;
    logic [WIDTH-1:0]   mag_b;

    // -2^(WIDTH-1) maps onto 2^(WIDTH-1), still representable unsigned
    assign mag_a = i_a[WIDTH-1] ? -i_a : i_a;
    assign mag_b = i_b[WIDTH-1] ? -i_b : i_b;

    assign sum_d  = sum_q + (mplier_q[0] ? mcand_q : '0);
    assign o_done = busy_q & (cnt_q == CW'(WIDTH-1));
    // Product includes the final iteration so the parent can latch it on done
    assign o_prod = neg_q ? -sum_d : sum_d;

    // Load magnitudes on start, then one shift-add step per cycle
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            mcand_q  <= '0;
            mplier_q <= '0;
            sum_q    <= '0;
            cnt_q    <= '0;
            neg_q    <= 1'b0;
            busy_q   <= 1'b0;
        end else if (i_start) begin
            mcand_q  <= {{WIDTH{1'b0}}, mag_a};
            mplier_q <= mag_b;
            sum_q    <= '0;
            cnt_q    <= '0;
            neg_q    <= i_a[WIDTH-1] ^ i_b[WIDTH-1];
            busy_q   <= 1'b1;
        end else if (busy_q) begin
            sum_q    <= sum_d;
            mcand_q  <= mcand_q << 1;
            mplier_q <= mplier_q >> 1;
            cnt_q    <= cnt_q + CW'(1);
            busy_q   <= ~o_done;
        end
    end

endmodule

// File: rtl/alu_mc.sv
// Single-issue multi-cycle ALU: handshake, IDLE/MUL_RUN FSM,
// single-cycle datapath, accumulator and flag generation.
module alu_mc
    import alu_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input logic     i_clk,
    input logic     i_rst,
    alu_mc_if.slave bus
);
    state_t             state_q;
    state_t             state_d;
    logic [WIDTH-1:0]   result_q;
    logic [3:0]         flag_q;
    logic               valid_q;
    logic [WIDTH-1:0]   acc_q;
    logic [WIDTH-1:0]   acc_d;

    logic               ready;
    logic               accept;
    logic               mul_start;
    logic               mul_done;
    logic               valid_d;
    logic [2*WIDTH-1:0] prod;

    logic [WIDTH-1:0]   a;
    logic [WIDTH-1:0]   b;
    logic [2:0]         op;
    logic [2*WIDTH-1:0] cat;
    logic [WIDTH-1:0]   diff;
    logic [WIDTH-1:0]   sum;
    logic               sub_ovf;
    logic               acc_ovf;
    logic               mul_ovf;

    logic [WIDTH-1:0]   lones;
    logic [WIDTH-1:0]   oh_idx;
    logic               run;
    logic               found;
    logic               multi;

    logic [WIDTH-1:0]   y_d;
    logic               err_d;
    logic               ovf_d;
    logic [3:0]         flag_d;

    assign a   = bus.i_arg0;
    assign b   = bus.i_arg1;
    assign op  = bus.i_oper;
    assign cat = {b, a};

    assign accept = bus.i_valid & ready;

    assign diff    = b - a;
    assign sum     = acc_q + a;
    assign sub_ovf = (a[WIDTH-1] ^ b[WIDTH-1]) & (diff[WIDTH-1] ^ b[WIDTH-1]);
    assign acc_ovf = ~(a[WIDTH-1] ^ acc_q[WIDTH-1]) & (sum[WIDTH-1] ^ acc_q[WIDTH-1]);
    // Fits WIDTH signed only if the top WIDTH+1 bits are a pure sign extension
    assign mul_ovf = ~(&prod[2*WIDTH-1:WIDTH-1]) & (|prod[2*WIDTH-1:WIDTH-1]);

    alu_mul_iter #(
        .WIDTH(WIDTH)
    ) u_mul (
        .i_clk  (i_clk),
        .i_rst  (i_rst),
        .i_start(mul_start),
        .i_a    (a),
        .i_b    (b),
        .o_done (mul_done),
        .o_prod (prod)
    );

    // FSM state register
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) state_q <= IDLE;
        else       state_q <= state_d;
    end

    // FSM next state: only MUL leaves IDLE
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE:    if (accept && op == OP_MUL) state_d = MUL_RUN;
            MUL_RUN: if (mul_done)               state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // FSM outputs: readiness, multiplier kick-off, result strobe
    always_comb begin
        ready     = (state_q == IDLE);
        mul_start = accept & (op == OP_MUL);
        valid_d   = (accept & (op != OP_MUL)) | ((state_q == MUL_RUN) & mul_done);
    end

    // Scan {B,A}: leading-ones run from the top, and one-hot position
    always_comb begin
        lones  = '0;
        oh_idx = '0;
        run    = 1'b1;
        found  = 1'b0;
        multi  = 1'b0;
        for (int i = 2*WIDTH-1; i >= 0; i--) begin
            if (run && cat[i]) lones = lones + WIDTH'(1);
            else               run   = 1'b0;
            if (cat[i]) begin
                multi  = multi | found;
                found  = 1'b1;
                oh_idx = WIDTH'(i);
            end
        end
    end

    // Result select; in MUL_RUN the multiplier owns the result path
    always_comb begin
        y_d   = '0;
        err_d = 1'b0;
        ovf_d = 1'b0;
        acc_d = acc_q;
        if (state_q == MUL_RUN) begin
            y_d   = prod[WIDTH-1:0];
            ovf_d = mul_ovf;
        end else begin
            unique case (op)
                OP_SUB: begin
                    y_d   = diff;
                    ovf_d = sub_ovf;
                end
                OP_NAND:  y_d = ~(a & b);
                OP_LONES: y_d = lones;
                OP_OHDEC: begin
                    y_d   = (found & ~multi) ? oh_idx : '0;
                    err_d = ~(found & ~multi);
                end
                OP_MUL: y_d = '0;
                OP_ACC: begin
                    acc_d = sum;
                    y_d   = sum;
                    ovf_d = acc_ovf;
                end
                OP_ACLR: acc_d = '0;
                OP_RSVD: err_d = 1'b1;
                default: err_d = 1'b1;
            endcase
        end
        flag_d                = 4'b0000;
        flag_d[FLAG_ERR]      = err_d;
        flag_d[FLAG_NEG]      = y_d[WIDTH-1];
        flag_d[FLAG_POS]      = (|y_d) & ~y_d[WIDTH-1];
        flag_d[FLAG_OVERFLOW] = ovf_d;
    end

    // Result/flag registers hold between strobes; accumulator moves on accept
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            result_q <= '0;
            flag_q   <= '0;
            valid_q  <= 1'b0;
            acc_q    <= '0;
        end else begin
            valid_q <= valid_d;
            if (valid_d) begin
                result_q <= y_d;
                flag_q   <= flag_d;
            end
            if (accept) acc_q <= acc_d;
        end
    end

    assign bus.o_ready  = ready;
    assign bus.o_result = result_q;
    assign bus.o_valid  = valid_q;
    assign bus.o_flag   = flag_q;

endmodule

// File: tb/tb_alu_mc.sv
// Directed bench for alu_mc at WIDTH=8 with hand-computed expectations.
// Inputs change 1 time unit after a rising edge; outputs sampled there too.
module tb_alu_mc;
    import alu_pkg::*;

    localparam int W = 8;

    logic clk = 1'b1;
    logic rst = 1'b1;
    int   n_chk  = 0;
    int   n_pass = 0;
    logic seen;

    alu_mc_if #(.WIDTH(W)) bus();

    alu_mc #(.WIDTH(W)) dut (
        .i_clk(clk),
        .i_rst(rst),
        .bus  (bus)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic [2:0] op, input logic [7:0] a,
                         input logic [7:0] b);
        bus.i_oper  = op;
        bus.i_arg0  = a;
        bus.i_arg1  = b;
        bus.i_valid = 1'b1;
    endtask

    task automatic one(input logic [2:0] op, input logic [7:0] a,
                       input logic [7:0] b);
        drive(op, a, b);
        tick();
        bus.i_valid = 1'b0;
    endtask

    task automatic res(input string tag, input logic [7:0] y,
                       input logic [3:0] f);
        chk({tag, " valid"}, 32'(bus.o_valid), 32'd1);
        chk({tag, " y"},     32'(bus.o_result), 32'(y));
        chk({tag, " flag"},  32'(bus.o_flag), 32'(f));
    endtask

    task automatic idle_chk(input string tag);
        chk({tag, " valid"}, 32'(bus.o_valid), 32'd0);
        chk({tag, " ready"}, 32'(bus.o_ready), 32'd1);
        chk({tag, " y"},     32'(bus.o_result), 32'd0);
        chk({tag, " flag"},  32'(bus.o_flag), 32'd0);
    endtask

    task automatic mul(input string tag, input logic [7:0] a,
                       input logic [7:0] b, input logic [7:0] y,
                       input logic [3:0] f);
        one(OP_MUL, a, b);
        repeat (8) tick();
        res(tag, y, f);
    endtask

    initial begin
        bus.i_valid = 1'b0;
        bus.i_oper  = 3'b000;
        bus.i_arg0  = 8'h00;
        bus.i_arg1  = 8'h00;

        #11;
        idle_chk("in_reset");
        #4;
        rst = 1'b0;
        tick();
        idle_chk("idle1");
        tick();
        idle_chk("idle2");

        one(OP_SUB, 8'd4, 8'd7);
        res("sub", 8'd3, 4'b0100);
        one(OP_SUB, 8'd1, 8'h80);
        res("sub_ovf", 8'h7F, 4'b1100);

        drive(OP_NAND, 8'hFF, 8'h01);
        tick();
        res("b2b nand", 8'hFE, 4'b0010);
        drive(OP_LONES, 8'hF0, 8'hFF);
        tick();
        res("b2b lones12", 8'd12, 4'b0100);
        drive(OP_LONES, 8'hFF, 8'hFF);
        tick();
        res("b2b lones16", 8'd16, 4'b0100);
        drive(OP_OHDEC, 8'h40, 8'h00);
        tick();
        res("b2b ohdec6", 8'd6, 4'b0100);
        drive(OP_OHDEC, 8'h41, 8'h00);
        tick();
        bus.i_valid = 1'b0;
        res("b2b ohdec_err", 8'd0, 4'b0001);
        tick();
        chk("b2b end valid", 32'(bus.o_valid), 32'd0);
        chk("b2b hold y", 32'(bus.o_result), 32'd0);

        one(OP_MUL, 8'hFD, 8'h05);
        chk("mul busy0 ready", 32'(bus.o_ready), 32'd0);
        chk("mul busy0 valid", 32'(bus.o_valid), 32'd0);
        drive(OP_SUB, 8'd1, 8'd1);
        for (int k = 1; k <= 7; k++) begin
            tick();
            if (k == 4) bus.i_valid = 1'b0;
            chk($sformatf("mul busy%0d ready", k), 32'(bus.o_ready), 32'd0);
            chk($sformatf("mul busy%0d valid", k), 32'(bus.o_valid), 32'd0);
        end
        tick();
        res("mul -3*5", 8'hF1, 4'b0010);
        chk("mul done ready", 32'(bus.o_ready), 32'd1);
        tick();
        chk("busy req dropped", 32'(bus.o_valid), 32'd0);
        chk("mul hold y", 32'(bus.o_result), 32'hF1);

        mul("mul 16*16", 8'd16, 8'd16, 8'h00, 4'b1000);
        mul("mul min*min", 8'h80, 8'h80, 8'h00, 4'b1000);
        mul("mul -1*-1", 8'hFF, 8'hFF, 8'h01, 4'b0100);

        one(OP_ACLR, 8'd0, 8'd0);
        res("aclr", 8'd0, 4'b0000);
        one(OP_ACC, 8'd100, 8'd0);
        res("acc 100", 8'd100, 4'b0100);
        one(OP_ACC, 8'd100, 8'd0);
        res("acc wrap", 8'hC8, 4'b1010);
        one(OP_ACLR, 8'd0, 8'd0);
        res("aclr2", 8'd0, 4'b0000);
        one(OP_RSVD, 8'h12, 8'h34);
        res("rsvd", 8'd0, 4'b0001);

        one(OP_ACC, 8'd5, 8'd0);
        res("acc 5", 8'd5, 4'b0100);
        one(OP_MUL, 8'd2, 8'd3);
        repeat (3) tick();
        rst = 1'b1;
        #2;
        idle_chk("abort rst");
        rst = 1'b0;
        seen = 1'b0;
        repeat (12) begin
            tick();
            if (bus.o_valid) seen = 1'b1;
        end
        chk("abort no valid", 32'(seen), 32'd0);
        chk("abort ready", 32'(bus.o_ready), 32'd1);
        one(OP_ACC, 8'd1, 8'd0);
        res("acc after abort", 8'd1, 4'b0100);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
